// File: rtl/sub_share_pkg.sv
// Shared types and constants for the subtractor-sharing arbiter.
package sub_share_pkg;
  localparam int OPW     = 2;
  localparam int STATS_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/sub_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  int   pos;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = IW'(pos);
      end
    end
  end
endmodule

// File: rtl/substractor_2bit.sv
// 2-bit subtractor computing a + ((~b + 1) mod 4); carry is the bit that
// falls out of that 2-bit addition.
module substractor_2bit
  import sub_share_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [OPW-1:0] diff,
  output logic           carry
);
  logic [OPW-1:0] b_neg;
  logic [OPW:0]   sum;

  // Negation wraps first, so b=0 adds zero and produces no carry.
  assign b_neg = ~b + OPW'(1);
  assign sum   = {1'b0, a} + {1'b0, b_neg};
  assign diff  = sum[OPW-1:0];
  assign carry = sum[OPW];
endmodule

// File: rtl/sub_share_arbiter.sv
// Round-robin sharing of one 2-bit subtractor among NUM_REQ requesters.
// Optional statistics outputs (op_count, conflict) under SUB_SHARE_STATS_EN.
module sub_share_arbiter
  import sub_share_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*OPW-1:0] req_a,
  input  logic [NUM_REQ*OPW-1:0] req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [OPW-1:0]         resp_result,
  output logic                   resp_sign
`ifdef SUB_SHARE_STATS_EN
  ,
  output logic [STATS_W-1:0]     op_count,
  output logic                   conflict
`endif
);
  state_t           state_reg;
  logic [IDW-1:0]   ptr_reg;
  logic [OPW-1:0]   op_a_reg;
  logic [OPW-1:0]   op_b_reg;
  logic [IDW-1:0]   op_id_reg;
  logic             resp_valid_reg;
  logic [IDW-1:0]   resp_id_reg;
  logic [OPW-1:0]   resp_result_reg;
  logic             resp_sign_reg;

  logic [OPW-1:0]   a_arr [NUM_REQ];
  logic [OPW-1:0]   b_arr [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]   win_idx;
  logic [OPW-1:0]   sub_diff;
  logic             sub_carry;
  logic [IDW-1:0]   ptr_next;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*OPW +: OPW];
    assign b_arr[gi] = req_b[gi*OPW +: OPW];
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (win_idx)
  );

  substractor_2bit u_sub (
    .a     (op_a_reg),
    .b     (op_b_reg),
    .diff  (sub_diff),
    .carry (sub_carry)
  );

  assign req_ready = (!rst && state_reg == IDLE) ? grant : '0;
  assign ptr_next  = (op_id_reg == IDW'(NUM_REQ - 1)) ? '0 : op_id_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      op_a_reg        <= '0;
      op_b_reg        <= '0;
      op_id_reg       <= '0;
      resp_valid_reg  <= 1'b0;
      resp_id_reg     <= '0;
      resp_result_reg <= '0;
      resp_sign_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req_valid) begin
            op_a_reg  <= a_arr[win_idx];
            op_b_reg  <= b_arr[win_idx];
            op_id_reg <= win_idx;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          resp_result_reg <= sub_diff;
          resp_sign_reg   <= sub_carry;
          resp_id_reg     <= op_id_reg;
          resp_valid_reg  <= 1'b1;
          ptr_reg         <= ptr_next;
          state_reg       <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign resp_valid  = resp_valid_reg;
  assign resp_id     = resp_id_reg;
  assign resp_result = resp_result_reg;
  assign resp_sign   = resp_sign_reg;

`ifdef SUB_SHARE_STATS_EN
  logic [STATS_W-1:0] op_count_reg;
  logic               conflict_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_reg <= '0;
      conflict_reg <= 1'b0;
    end else begin
      if (resp_valid_reg && resp_ready && op_count_reg != '1)
        op_count_reg <= op_count_reg + 1'b1;
      // More than one bit set: clearing the lowest set bit leaves something.
      conflict_reg <= (state_reg == IDLE) &&
                      ((req_valid & (req_valid - 1'b1)) != '0);
    end
  end

  assign op_count = op_count_reg;
  assign conflict = conflict_reg;
`endif
endmodule

// File: tb/tb_sub_share_arbiter.sv
// Directed self-checking bench for sub_share_arbiter (NUM_REQ=4).
module tb_sub_share_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [3:0] req_ready;
  logic       resp_valid;
  logic       resp_ready;
  logic [1:0] resp_id;
  logic [1:0] resp_result;
  logic       resp_sign;
`ifdef SUB_SHARE_STATS_EN
  logic [7:0] op_count;
  logic       conflict;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sub_share_arbiter #(.NUM_REQ(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_sign   (resp_sign)
`ifdef SUB_SHARE_STATS_EN
    ,
    .op_count    (op_count),
    .conflict    (conflict)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [1:0] a, input logic [1:0] b);
    req_a[2*i +: 2] = a;
    req_b[2*i +: 2] = b;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0; resp_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if (resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_result !== 2'd0 || resp_sign !== 1'b0) begin
      n_err++;
      $display("FAIL reset_resp: valid=%b id=%0d res=%0d sign=%b required 0/0/0/0",
               resp_valid, resp_id, resp_result, resp_sign);
    end
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL reset_ready: got %b required 0000", req_ready);
    end
    req_valid = 4'b0000;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_basic();
    set_ops(0, 2'd3, 2'd1);
    req_valid = 4'b0001; #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL basic_grant: got %b required 0001", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    n_cmp++;
    if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_exec: ready=%b valid=%b required 0000/0", req_ready, resp_valid);
    end
    tick();
    $display("resp id=%0d result=%0d sign=%b", resp_id, resp_result, resp_sign);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_result !== 2'd2 || resp_sign !== 1'b1) begin
      n_err++;
      $display("FAIL basic_resp: valid=%b id=%0d res=%0d sign=%b required 1/0/2/1",
               resp_valid, resp_id, resp_result, resp_sign);
    end
    tick();
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_release: valid=%b required 0", resp_valid);
    end
  endtask

  // Pointer is 1 here; requester 2 is the only one asking.
  task automatic test_req2();
    set_ops(2, 2'd1, 2'd2);
    req_valid = 4'b0100; #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++; $display("FAIL req2_grant: got %b required 0100", req_ready);
    end
    tick(); req_valid = 4'b0000; tick();
    $display("resp id=%0d result=%0d sign=%b", resp_id, resp_result, resp_sign);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_result !== 2'd3 || resp_sign !== 1'b0) begin
      n_err++;
      $display("FAIL req2_resp: valid=%b id=%0d res=%0d sign=%b required 1/2/3/0",
               resp_valid, resp_id, resp_result, resp_sign);
    end
    tick();
  endtask

  task automatic test_b_zero();
    set_ops(3, 2'd2, 2'd0);
    req_valid = 4'b1000; #1;
    tick(); req_valid = 4'b0000; tick();
    $display("resp id=%0d result=%0d sign=%b", resp_id, resp_result, resp_sign);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_result !== 2'd2 || resp_sign !== 1'b0) begin
      n_err++;
      $display("FAIL bzero_resp: valid=%b id=%0d res=%0d sign=%b required 1/3/2/0",
               resp_valid, resp_id, resp_result, resp_sign);
    end
    tick();
  endtask

  // Pointer is 0. Slot i holds a=3, b=i: results 3,2,1,0 and signs 0,1,1,1.
  task automatic test_round_robin();
    logic [1:0] exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] exp_res [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    logic       exp_sgn [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] exp_gnt;
    for (int i = 0; i < 4; i++) set_ops(i, 2'd3, 2'(i));
    req_valid = 4'b1111; resp_ready = 1'b1; #1;
    for (int n = 0; n < 5; n++) begin
      exp_gnt = 4'b0001 << exp_id[n];
      n_cmp++;
      if (req_ready !== exp_gnt) begin
        n_err++; $display("FAIL rr_grant[%0d]: got %b required %b", n, req_ready, exp_gnt);
      end
      tick();
      n_cmp++;
      if (req_ready !== 4'b0000) begin
        n_err++; $display("FAIL rr_exec_ready[%0d]: got %b required 0000", n, req_ready);
      end
      tick();
      $display("resp id=%0d result=%0d sign=%b", resp_id, resp_result, resp_sign);
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_id !== exp_id[n] || resp_result !== exp_res[n] ||
          resp_sign !== exp_sgn[n]) begin
        n_err++;
        $display("FAIL rr_resp[%0d]: valid=%b id=%0d res=%0d sign=%b required 1/%0d/%0d/%b",
                 n, resp_valid, resp_id, resp_result, resp_sign, exp_id[n], exp_res[n], exp_sgn[n]);
      end
      tick();
    end
    req_valid = 4'b0000; #1;
  endtask

  // Pointer is 1; slot 1 holds a=3, b=1.
  task automatic test_backpressure();
    req_valid = 4'b1111; resp_ready = 1'b0; #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL bp_grant: got %b required 0010", req_ready);
    end
    tick(); tick();
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_result !== 2'd2 || resp_sign !== 1'b1 ||
          req_ready !== 4'b0000) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: valid=%b id=%0d res=%0d sign=%b ready=%b required 1/1/2/1/0000",
                 c, resp_valid, resp_id, resp_result, resp_sign, req_ready);
      end
      tick();
    end
    $display("resp id=%0d result=%0d sign=%b", resp_id, resp_result, resp_sign);
    resp_ready = 1'b1;
    tick();
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b0100) begin
      n_err++; $display("FAIL bp_release: valid=%b ready=%b required 0/0100", resp_valid, req_ready);
    end
    req_valid = 4'b0000; #1;
  endtask

  // Pointer is 2. Abort an op in EXEC; pointer must return to 0.
  task automatic test_reset_mid();
    req_valid = 4'b0001; #1;
    tick();
    req_valid = 4'b0110;
    rst = 1'b1;
    tick();
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      n_err++; $display("FAIL rstmid_state: valid=%b ready=%b required 0/0000", resp_valid, req_ready);
    end
    rst = 1'b0;
    set_ops(1, 2'd3, 2'd1);
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL rstmid_grant: got %b required 0010", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    set_ops(1, 2'd0, 2'd3);
    tick();
    $display("resp id=%0d result=%0d sign=%b", resp_id, resp_result, resp_sign);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_result !== 2'd2 || resp_sign !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_resp: valid=%b id=%0d res=%0d sign=%b required 1/1/2/1",
               resp_valid, resp_id, resp_result, resp_sign);
    end
    tick();
  endtask

`ifdef SUB_SHARE_STATS_EN
  task automatic test_stats();
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++;
    if (op_count !== 8'd0) begin
      n_err++; $display("FAIL stats_reset: op_count=%0d required 0", op_count);
    end
    req_valid = 4'b0011; #1;
    tick();
    n_cmp++;
    if (conflict !== 1'b1) begin
      n_err++; $display("FAIL stats_conflict: got %b required 1", conflict);
    end
    req_valid = 4'b0001;
    for (int c = 0; c < 905; c++) tick();
    req_valid = 4'b0000;
    tick(); tick(); tick();
    n_cmp++;
    if (op_count !== 8'd255) begin
      n_err++; $display("FAIL stats_saturate: op_count=%0d required 255", op_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_req2();
    test_b_zero();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
`ifdef SUB_SHARE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
